// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: two-port round-robin arbiter and sequencer for the
// single-port data memory. One transaction at a time walks
// IDLE -> ISSUE -> RESP; illegal or misaligned commands run through the
// same three steps but never touch memory.
module dmem_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 iClk,
  input  logic                                 iRst,
  input  logic [NUM_REQ-1:0]                   iReqValid,
  input  logic [NUM_REQ-1:0]                   iReqWrite,
  input  logic [NUM_REQ-1:0][2:0]              iReqFunct3,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   iReqAddr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   iReqWData,
  output logic [NUM_REQ-1:0]                   oReqReady,
  output logic [NUM_REQ-1:0]                   oRespValid,
  output logic                                 oRespError,
  output logic [DATA_WIDTH-1:0]                oRespRData,
  output logic                                 oMemWriteEn,
  output logic                                 oMemIsLoad,
  output logic [2:0]                           oMemFunct3,
  output logic [ADDR_WIDTH-1:0]                oMemAddress,
  output logic [DATA_WIDTH-1:0]                oMemData,
  input  logic [DATA_WIDTH-1:0]                iMemData
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  rr_last;
  logic                  gnt_id;
  logic                  accept;
  logic                  gnt_err;

  // latched command
  logic                  cur_id;
  logic                  cur_write;
  logic                  cur_err;
  logic [2:0]            cur_funct3;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Legal size codes per direction plus natural alignment of halves/words.
  function automatic logic cmd_err(input logic wr, input logic [2:0] f3,
                                   input logic [1:0] a);
    logic illegal, misaligned;
    if (wr) illegal = (f3 > 3'b010);
    else    illegal = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                 ((f3[1:0] == 2'b10) && (a != 2'b00));
    return illegal | misaligned;
  endfunction

  // Round-robin pick: a lone requester always wins; on contention the port
  // that was not granted last goes first. Nothing is granted under reset.
  always_comb begin
    oReqReady = '0;
    gnt_id    = 1'b0;
    accept    = 1'b0;
    if (state_q == IDLE && !iRst && (|iReqValid)) begin
      if (iReqValid[0] && iReqValid[1]) gnt_id = ~rr_last;
      else                              gnt_id = iReqValid[1];
      oReqReady[gnt_id] = 1'b1;
      accept            = 1'b1;
    end
  end

  assign gnt_err = cmd_err(iReqWrite[gnt_id], iReqFunct3[gnt_id],
                           iReqAddr[gnt_id][1:0]);

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: fixed three-step walk, leaving IDLE only on acceptance
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, arbitration pointer and read-data capture
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rr_last    <= 1'b1;
      cur_id     <= 1'b0;
      cur_write  <= 1'b0;
      cur_err    <= 1'b0;
      cur_funct3 <= '0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        rr_last    <= gnt_id;
        cur_id     <= gnt_id;
        cur_write  <= iReqWrite[gnt_id];
        cur_err    <= gnt_err;
        cur_funct3 <= iReqFunct3[gnt_id];
        cur_addr   <= iReqAddr[gnt_id];
        cur_wdata  <= iReqWData[gnt_id];
      end
      // memory updates iMemData on the ISSUE negedge; take it at the close
      if (state_q == ISSUE)
        rdata_q <= (!cur_write && !cur_err) ? iMemData : '0;
    end
  end

  // Memory side: strobes only in ISSUE, bus fields hold the last command
  always_comb begin
    oMemWriteEn = (state_q == ISSUE) &&  cur_write && !cur_err;
    oMemIsLoad  = (state_q == ISSUE) && !cur_write && !cur_err;
    oMemFunct3  = cur_funct3;
    oMemAddress = cur_addr;
    oMemData    = cur_wdata;
  end

  // Response pulse routed to the owning requester
  always_comb begin
    oRespValid = '0;
    oRespError = 1'b0;
    oRespRData = '0;
    if (state_q == RESP) begin
      oRespValid[cur_id] = 1'b1;
      oRespError         = cur_err;
      oRespRData         = rdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural negedge memory, a table of
// single-port transactions, and hand sequences for contention and reset.
module tb_dmem_port_arbiter;

  logic             iClk = 1'b0;
  logic             iRst;
  logic [1:0]       iReqValid;
  logic [1:0]       iReqWrite;
  logic [1:0][2:0]  iReqFunct3;
  logic [1:0][31:0] iReqAddr;
  logic [1:0][31:0] iReqWData;
  logic [1:0]       oReqReady;
  logic [1:0]       oRespValid;
  logic             oRespError;
  logic [31:0]      oRespRData;
  logic             oMemWriteEn;
  logic             oMemIsLoad;
  logic [2:0]       oMemFunct3;
  logic [31:0]      oMemAddress;
  logic [31:0]      oMemData;
  logic [31:0]      iMemData;

  int passed = 0;
  int total  = 0;

  dmem_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .iClk(iClk), .iRst(iRst),
    .iReqValid(iReqValid), .iReqWrite(iReqWrite), .iReqFunct3(iReqFunct3),
    .iReqAddr(iReqAddr), .iReqWData(iReqWData), .oReqReady(oReqReady),
    .oRespValid(oRespValid), .oRespError(oRespError), .oRespRData(oRespRData),
    .oMemWriteEn(oMemWriteEn), .oMemIsLoad(oMemIsLoad), .oMemFunct3(oMemFunct3),
    .oMemAddress(oMemAddress), .oMemData(oMemData), .iMemData(iMemData)
  );

  always #5 iClk = ~iClk;

  // little-endian byte memory, 64 words, acting on the falling edge
  logic [31:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]       = 32'h0BADF00D;
    mem[32'h10>>2] = 32'hDEADBEEF;
    iMemData = 32'h0;
  end

  always @(negedge iClk) begin
    logic [31:0] w, sh;
    w  = mem[oMemAddress[7:2]];
    sh = w >> (8 * oMemAddress[1:0]);
    if (oMemWriteEn) begin
      case (oMemFunct3[1:0])
        2'b00:   w[8*oMemAddress[1:0] +: 8]   = oMemData[7:0];
        2'b01:   w[8*oMemAddress[1:0] +: 16]  = oMemData[15:0];
        default: w = oMemData;
      endcase
      mem[oMemAddress[7:2]] = w;
    end
    if (oMemIsLoad) begin
      case (oMemFunct3)
        3'b000:  iMemData <= {{24{sh[7]}}, sh[7:0]};
        3'b001:  iMemData <= {{16{sh[15]}}, sh[15:0]};
        3'b100:  iMemData <= {24'h0, sh[7:0]};
        3'b101:  iMemData <= {16'h0, sh[15:0]};
        default: iMemData <= w;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  typedef struct packed {
    logic        port;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [16];

  // One transaction on one port, starting at posedge+1 of an IDLE cycle
  task automatic run_txn(input vec_t v);
    logic [1:0] onehot;
    onehot = 2'b01 << v.port;
    iReqValid = onehot;
    iReqWrite[v.port]  = v.wr;
    iReqFunct3[v.port] = v.f3;
    iReqAddr[v.port]   = v.addr;
    iReqWData[v.port]  = v.wdata;
    #1;
    chk("ready", {30'h0, oReqReady}, {30'h0, onehot});
    tick();
    iReqValid = 2'b00;
    #1;
    chk("issue_we", {31'h0, oMemWriteEn}, {31'h0, v.wr & ~v.err});
    chk("issue_ld", {31'h0, oMemIsLoad}, {31'h0, ~v.wr & ~v.err});
    chk("issue_addr", oMemAddress, v.addr);
    chk("issue_f3", {29'h0, oMemFunct3}, {29'h0, v.f3});
    tick();
    chk("resp_valid", {30'h0, oRespValid}, {30'h0, onehot});
    chk("resp_err", {31'h0, oRespError}, {31'h0, v.err});
    chk("resp_rdata", oRespRData, v.rdata);
    chk("resp_we_off", {31'h0, oMemWriteEn}, 32'h0);
    tick();
    chk("idle_resp", {30'h0, oRespValid}, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b1, 3'b000, 32'h23, 32'h000000A5, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h23, 32'h0,        1'b0, 32'h000000A5};
    vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h23, 32'h0,        1'b0, 32'hFFFFFFA5};
    vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h14, 32'hBEEF5678, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 3'b001, 32'h16, 32'h00009ABC, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 3'b101, 32'h14, 32'h0,        1'b0, 32'h00005678};
    vecs[7]  = '{1'b0, 1'b0, 3'b001, 32'h16, 32'h0,        1'b0, 32'hFFFF9ABC};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h14, 32'h0,        1'b0, 32'h9ABC5678};
    vecs[9]  = '{1'b0, 1'b0, 3'b010, 32'h12, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 3'b001, 32'h21, 32'h0000FFFF, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 3'b011, 32'h10, 32'h0,        1'b1, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h20, 32'h00000077, 1'b1, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h20, 32'h0,        1'b0, 32'hA5000000};
    vecs[14] = '{1'b0, 1'b1, 3'b010, 32'h20, 32'h12345678, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 3'b100, 32'h21, 32'h0,        1'b0, 32'h00000056};

    // reset with both ports requesting: nothing may be accepted
    iRst = 1'b1;
    iReqValid  = 2'b11;
    iReqWrite  = 2'b00;
    iReqFunct3 = {3'b010, 3'b010};
    iReqAddr   = {32'h0, 32'h10};
    iReqWData  = '0;
    tick();
    tick();
    chk("rst_ready", {30'h0, oReqReady}, 32'h0);
    chk("rst_resp", {30'h0, oRespValid}, 32'h0);
    chk("rst_err", {31'h0, oRespError}, 32'h0);
    chk("rst_rdata", oRespRData, 32'h0);
    chk("rst_we", {31'h0, oMemWriteEn}, 32'h0);
    chk("rst_ld", {31'h0, oMemIsLoad}, 32'h0);
    chk("rst_f3", {29'h0, oMemFunct3}, 32'h0);
    chk("rst_addr", oMemAddress, 32'h0);
    chk("rst_data", oMemData, 32'h0);

    // contention: both ports hold valid, 4 loads each, grants alternate 0,1,...
    begin
      int left0, left1;
      logic [1:0] exp;
      left0 = 4;
      left1 = 4;
      iRst = 1'b0;
      for (int i = 0; i < 8; i++) begin
        iReqValid = {left1 > 0, left0 > 0};
        #1;
        exp = (i % 2 == 0) ? 2'b01 : 2'b10;
        chk("rr_grant", {30'h0, oReqReady}, {30'h0, exp});
        if (exp[0]) left0--; else left1--;
        tick();
        iReqValid = {left1 > 0, left0 > 0};
        #1;
        chk("rr_issue_ready", {30'h0, oReqReady}, 32'h0);
        tick();
        chk("rr_resp_valid", {30'h0, oRespValid}, {30'h0, exp});
        chk("rr_resp_rdata", oRespRData, exp[0] ? 32'hDEADBEEF : 32'h0BADF00D);
        tick();
      end
      iReqValid = 2'b00;
    end

    for (int i = 0; i < 16; i++) run_txn(vecs[i]);

    // reset landing in the ISSUE cycle of a store
    iReqValid    = 2'b10;
    iReqWrite[1]  = 1'b1;
    iReqFunct3[1] = 3'b010;
    iReqAddr[1]   = 32'h30;
    iReqWData[1]  = 32'hCAFEF00D;
    #1;
    chk("ri_ready", {30'h0, oReqReady}, 32'h2);
    tick();
    iReqValid = 2'b00;
    iRst = 1'b1;
    #1;
    chk("ri_we", {31'h0, oMemWriteEn}, 32'h1);
    tick();
    iRst = 1'b0;
    #1;
    chk("ri_no_resp", {30'h0, oRespValid}, 32'h0);
    chk("ri_ready0", {30'h0, oReqReady}, 32'h0);
    chk("ri_we0", {31'h0, oMemWriteEn}, 32'h0);
    chk("ri_addr0", oMemAddress, 32'h0);
    chk("ri_data0", oMemData, 32'h0);
    chk("ri_f30", {29'h0, oMemFunct3}, 32'h0);
    chk("ri_rdata0", oRespRData, 32'h0);
    chk("ri_mem", mem[32'h30>>2], 32'hCAFEF00D);
    tick();
    iReqValid     = 2'b11;
    iReqWrite     = 2'b00;
    iReqFunct3    = {3'b010, 3'b010};
    iReqAddr      = {32'h10, 32'h30};
    #1;
    chk("ri_next_grant", {30'h0, oReqReady}, 32'h1);
    tick();
    iReqValid = 2'b00;
    tick();
    chk("ri_next_resp", {30'h0, oRespValid}, 32'h1);
    chk("ri_next_rdata", oRespRData, 32'hCAFEF00D);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
